banked_burst_memctrl: RTL and testbench

//  Parametrised successor to the fixed 4x512x8 controller. Presents one request/response

---
 rtl/banked_burst_memctrl.sv | 159 +++++++++++++++
 tb/tb_banked_burst_memctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_burst_memctrl.sv
// Burst memory controller: one valid/ready request port in front of NBANK synchronous SRAM banks
// sharing address/data lines, with auto-incrementing bursts and a registered read-data return path.
`timescale 1ns/1ps
module banked_burst_memctrl #(
  parameter int DW        = 8,
  parameter int BANK_AW   = 9,
  parameter int NBANK     = 4,
  parameter int BURST_MAX = 4,
  localparam int NB = $clog2(NBANK),
  localparam int LW = $clog2(BURST_MAX),
  localparam int AW = BANK_AW + NB
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [AW-1:0]       REQ_ADDR,
  input  logic [LW-1:0]       REQ_LEN,
  input  logic                WD_VALID,
  output logic                WD_READY,
  input  logic [DW-1:0]       WD_DATA,
  output logic                RD_VALID,
  output logic [DW-1:0]       RD_DATA,
  output logic                RD_LAST,
  output logic [BANK_AW-1:0]  MEM_ADDR,
  output logic                MEM_CE,
  output logic                MEM_WEB,
  output logic [NBANK-1:0]    MEM_OEB,
  output logic [NBANK-1:0]    MEM_CSB,
  output logic [DW-1:0]       MEM_IDATA,
  input  logic [NBANK*DW-1:0] MEM_ODATA
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    cnt_q, cnt_d;

  logic             cmd_valid, cmd_we, cmd_last;
  logic [AW-1:0]    cmd_addr;
  logic [NB-1:0]    cmd_bank;
  logic [NBANK-1:0] cmd_sel_n;

  logic             p1_valid, p1_last, p2_valid, p2_last;
  logic [NB-1:0]    p1_bank, p2_bank;
  logic [DW-1:0]    rd_mux;

  assign REQ_READY = (state_q == IDLE) && !RST;
  assign WD_READY  = (state_q == WR) && !RST;

  assign cmd_bank  = cmd_addr[AW-1:BANK_AW];
  assign cmd_sel_n = ~(NBANK'(1) << cmd_bank);

  // A read request issues its first beat straight from the request fields so that the
  // command register holds beat 0 in the cycle right after the accepting edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_last  = 1'b0;
    cmd_addr  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          if (REQ_WE) begin
            state_d = WR;
            addr_d  = REQ_ADDR;
            cnt_d   = REQ_LEN;
          end else begin
            cmd_valid = 1'b1;
            cmd_addr  = REQ_ADDR;
            cmd_last  = (REQ_LEN == '0);
            addr_d    = REQ_ADDR + AW'(1);
            cnt_d     = REQ_LEN - LW'(1);
            state_d   = (REQ_LEN == '0) ? IDLE : RD;
          end
        end
      end
      WR: begin
        if (WD_VALID && WD_READY) begin
          cmd_valid = 1'b1;
          cmd_we    = 1'b1;
          addr_d    = addr_q + AW'(1);
          cnt_d     = cnt_q - LW'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      RD: begin
        cmd_valid = 1'b1;
        cmd_last  = (cnt_q == '0);
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q - LW'(1);
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (p2_bank == NB'(b)) rd_mux = MEM_ODATA[b*DW +: DW];
    end
  end

  // p1 tracks the cycle the command is on the bus, p2 the cycle its bank drives MEM_ODATA.
  always_ff @(posedge CLK) begin
    // NOTE: the read pipeline is reset along with the strobes so an aborted burst returns nothing.
    if (RST) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      MEM_ADDR  <= '0;
      MEM_CE    <= 1'b0;
      MEM_WEB   <= 1'b1;
      MEM_OEB   <= '1;
      MEM_CSB   <= '1;
      MEM_IDATA <= '0;
      p1_valid  <= 1'b0;
      p1_last   <= 1'b0;
      p1_bank   <= '0;
      p2_valid  <= 1'b0;
      p2_last   <= 1'b0;
      p2_bank   <= '0;
      RD_VALID  <= 1'b0;
      RD_DATA   <= '0;
      RD_LAST   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      MEM_CE   <= cmd_valid;
      MEM_WEB  <= !(cmd_valid && cmd_we);
      MEM_CSB  <= cmd_valid ? cmd_sel_n : '1;
      MEM_OEB  <= (cmd_valid && !cmd_we) ? cmd_sel_n : '1;
      if (cmd_valid)           MEM_ADDR  <= cmd_addr[BANK_AW-1:0];
      if (cmd_valid && cmd_we) MEM_IDATA <= WD_DATA;
      p1_valid <= cmd_valid && !cmd_we;
      p1_last  <= cmd_last;
      p1_bank  <= cmd_bank;
      p2_valid <= p1_valid;
      p2_last  <= p1_valid && p1_last;
      p2_bank  <= p1_bank;
      RD_VALID <= p2_valid;
      RD_LAST  <= p2_last;
      if (p2_valid) RD_DATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_banked_burst_memctrl.sv
// Bench for banked_burst_memctrl: SRAM bank models plus a flat-address reference memory;
// expected bus commands and read beats are timestamped per cycle and compared every cycle.
`timescale 1ns/1ps
module tb_banked_burst_memctrl;

  localparam int DW        = 8;
  localparam int BANK_AW   = 9;
  localparam int NBANK     = 4;
  localparam int BURST_MAX = 4;
  localparam int NB        = 2;
  localparam int LW        = 2;
  localparam int AW        = BANK_AW + NB;
  localparam int DEPTH     = 1 << BANK_AW;
  localparam int ASPACE    = 1 << AW;

  logic                CLK, RST;
  logic                REQ_VALID, REQ_READY, REQ_WE;
  logic [AW-1:0]       REQ_ADDR;
  logic [LW-1:0]       REQ_LEN;
  logic                WD_VALID, WD_READY;
  logic [DW-1:0]       WD_DATA;
  logic                RD_VALID, RD_LAST;
  logic [DW-1:0]       RD_DATA;
  logic [BANK_AW-1:0]  MEM_ADDR;
  logic                MEM_CE, MEM_WEB;
  logic [NBANK-1:0]    MEM_OEB, MEM_CSB;
  logic [DW-1:0]       MEM_IDATA;
  logic [NBANK*DW-1:0] MEM_ODATA;

  banked_burst_memctrl #(.DW(DW), .BANK_AW(BANK_AW), .NBANK(NBANK), .BURST_MAX(BURST_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB),
    .MEM_OEB(MEM_OEB), .MEM_CSB(MEM_CSB), .MEM_IDATA(MEM_IDATA),
    .MEM_ODATA(MEM_ODATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { int cyc; bit we; int bank; int addr; int data; } cmd_t;
  typedef struct { int cyc; int data; bit last; } rd_t;

  cmd_t        cmd_q[$];
  rd_t         rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cmds = 0;
  int          rd_pulses = 0;
  bit          mon_en = 1'b0;
  logic [DW-1:0] ref_mem [ASPACE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NBANK-1:0] sel_low(input int b);
    logic [NBANK-1:0] v;
    v = '1;
    v[b] = 1'b0;
    return v;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM banks: data appears one cycle after a read command; non-read cycles drive junk.
  logic [DW-1:0]       sram [NBANK][DEPTH];
  logic [NBANK*DW-1:0] odata;
  assign MEM_ODATA = odata;

  always @(posedge CLK) begin
    for (int b = 0; b < NBANK; b++) begin
      if (MEM_CE === 1'b1 && MEM_CSB[b] === 1'b0 && MEM_WEB === 1'b0)
        sram[b][MEM_ADDR] <= MEM_IDATA;
      else if (MEM_CE === 1'b1 && MEM_CSB[b] === 1'b0 && MEM_OEB[b] === 1'b0)
        odata[b*DW +: DW] <= sram[b][MEM_ADDR];
      else
        odata[b*DW +: DW] <= DW'($urandom);
    end
  end

  always @(negedge CLK) begin : monitor
    cmd_t c;
    rd_t  r;
    if (mon_en) begin
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        c = cmd_q.pop_front();
        check("cmd_missed", 32'(cyc), 32'(c.cyc));
      end
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        c = cmd_q.pop_front();
        check("cmd_ce", MEM_CE, 1);
        check("cmd_web", MEM_WEB, !c.we);
        check("cmd_csb", MEM_CSB, sel_low(c.bank));
        check("cmd_oeb", MEM_OEB, c.we ? {NBANK{1'b1}} : sel_low(c.bank));
        check("cmd_addr", MEM_ADDR, c.addr);
        if (c.we) check("cmd_idata", MEM_IDATA, c.data);
      end else begin
        check("idle_ce", MEM_CE, 0);
        check("idle_web", MEM_WEB, 1);
        check("idle_csb", MEM_CSB, {NBANK{1'b1}});
        check("idle_oeb", MEM_OEB, {NBANK{1'b1}});
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        r = rd_q.pop_front();
        check("rd_valid", RD_VALID, 1);
        check("rd_data", RD_DATA, r.data);
        check("rd_last", RD_LAST, r.last);
      end else begin
        check("rd_idle", RD_VALID, 0);
      end
      if (MEM_CE === 1'b1 && MEM_WEB === 1'b0) wr_cmds++;
      if (RD_VALID === 1'b1) rd_pulses++;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first cycle after the accepting edge.
  task automatic issue(input bit we, input int addr, input int len, output int e);
    int n;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = AW'(addr);
    REQ_LEN   = LW'(len);
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready", REQ_READY, 1);
    @(posedge CLK);
    #1;
    e = cyc;
    REQ_VALID = 1'b0;
    REQ_ADDR  = AW'($urandom);
  endtask

  task automatic do_read(input int addr, input int len, output int e);
    int full;
    WD_VALID = 1'b1;
    WD_DATA  = DW'($urandom);
    issue(1'b0, addr, len, e);
    for (int k = 0; k <= len; k++) begin
      full = (addr + k) % ASPACE;
      cmd_q.push_back('{e + k, 1'b0, full / DEPTH, full % DEPTH, 0});
      rd_q.push_back('{e + k + 2, int'(ref_mem[full]), (k == len)});
    end
  endtask

  task automatic do_write(input int addr, input int len, input int gap, input bit fixed,
                          input logic [BURST_MAX*DW-1:0] words);
    int e, w, g, full, n;
    logic [DW-1:0] d;
    WD_VALID = 1'b0;
    issue(1'b1, addr, len, e);
    for (int k = 0; k <= len; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((k == 0) ? 0 : gap);
      repeat (g) begin
        @(posedge CLK);
        #1;
      end
      d = fixed ? words[k*DW +: DW] : DW'($urandom);
      WD_VALID = 1'b1;
      WD_DATA  = d;
      n = 0;
      @(negedge CLK);
      while (!WD_READY && n < 20) begin
        @(negedge CLK);
        n++;
      end
      check("wd_ready", WD_READY, 1);
      @(posedge CLK);
      #1;
      w = cyc;
      WD_VALID = 1'b0;
      full = (addr + k) % ASPACE;
      cmd_q.push_back('{w, 1'b1, full / DEPTH, full % DEPTH, int'(d)});
      ref_mem[full] = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, w0, p0;
    logic [DW-1:0] v;
    RST = 1'b1;
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
    WD_VALID = 1'b0; WD_DATA = '0;
    for (int a = 0; a < ASPACE; a++) begin
      v = DW'($urandom);
      ref_mem[a] = v;
      sram[a / DEPTH][a % DEPTH] <= v;
    end

    // Reset held for two edges, then every output at its reset value.
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst_req_ready", REQ_READY, 0);
    check("rst_wd_ready", WD_READY, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    check("post_rst_req_ready", REQ_READY, 1);
    check("post_rst_wd_ready", WD_READY, 0);
    check("post_rst_rd_data", RD_DATA, 0);
    check("post_rst_rd_last", RD_LAST, 0);
    check("post_rst_mem_addr", MEM_ADDR, 0);
    check("post_rst_mem_idata", MEM_IDATA, 0);
    @(posedge CLK); #1;

    // Single beat at the top of bank 0, then read it back.
    do_write(32'h1FF, 0, 0, 1'b1, 32'h0000_00A5);
    do_read(32'h1FF, 0, e);

    // Four-beat write crossing from bank 0 into bank 1, read back on consecutive cycles.
    do_write(32'h1FE, 3, 0, 1'b1, 32'h4433_2211);
    do_read(32'h1FE, 3, e);

    // Read wrapping from the last address of bank 3 to address 0 of bank 0.
    do_read(32'h7FF, 1, e);

    // Write with two-cycle WD_VALID gaps between beats: exactly three write commands.
    repeat (4) begin @(posedge CLK); #1; end
    w0 = wr_cmds;
    do_write(32'h0A0, 2, 2, 1'b0, '0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("gap_wr_cmds", 32'(wr_cmds - w0), 3);

    // Random mix of bursts, back-to-back where the handshake allows.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, ASPACE - 1)), int'($urandom_range(0, BURST_MAX - 1)), -1, 1'b0, '0);
      else
        do_read(int'($urandom_range(0, ASPACE - 1)), int'($urandom_range(0, BURST_MAX - 1)), e);
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end
    repeat (6) begin @(posedge CLK); #1; end

    // Reset in the cycle after a read burst is accepted: only beat 0 reaches the bus.
    do_read(32'h3FE, 3, e);
    RST = 1'b1;
    while (cmd_q.size() > 0 && cmd_q[$].cyc > e) void'(cmd_q.pop_back());
    rd_q.delete();
    @(negedge CLK);
    check("abort_req_ready", REQ_READY, 0);
    check("abort_wd_ready", WD_READY, 0);
    p0 = rd_pulses;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (8) begin @(posedge CLK); #1; end
    check("abort_rd_pulses", 32'(rd_pulses - p0), 0);

    // Normal operation resumes with memory contents intact.
    do_read(32'h3FE, 3, e);
    WD_VALID = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    check("cmd_q_drained", 32'(cmd_q.size()), 0);
    check("rd_q_drained", 32'(rd_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
